// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, framing width and default bit period.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 8N1 framing payload width
  localparam int UART_DATA_BITS = 8;

  // 50 MHz core clock / 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles and flags the last cycle of each serial bit.
// Latency: tick asserts on the CLKS_PER_BIT-th cycle after clear is released.
// Backpressure: none; clear holds the count at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count up within a bit period, wrapping to zero on the last cycle so the count never exceeds LAST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART 8N1 transmitter: accepts a byte on valid/ready and serialises start, 8 data bits LSB first, stop.
// Latency: o_txd goes low the cycle after acceptance; frame lasts 10*CLKS_PER_BIT cycles, done on last stop cycle.
// Backpressure: o_tx_ready is high only when idle; valid while busy is ignored, nothing is queued.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_txd,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t          state, state_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic [IW-1:0]        idx, idx_nx;
  logic                 txd_q, txd_nx;
  logic                 tick;

  // Timer is held cleared while idle so the start bit gets a full period from acceptance
  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  assign o_tx_ready = (state == IDLE);
  assign o_tx_busy  = ~o_tx_ready;
  assign o_txd      = txd_q;

  // Next-state, shift register and next serial level; txd_nx is the level for the following cycle
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    idx_nx    = idx;
    txd_nx    = txd_q;
    o_tx_done = 1'b0;
    case (state)
      IDLE: begin
        txd_nx = 1'b1;
        if (i_tx_valid) begin
          state_nx = START;
          shreg_nx = i_tx_data;
          idx_nx   = '0;
          txd_nx   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_nx = DATA;
          txd_nx   = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nx = shreg >> 1;
          if (idx == LAST_IDX) begin
            state_nx = STOP;
            idx_nx   = '0;
            txd_nx   = 1'b1;
          end else begin
            idx_nx = idx + IW'(1);
            txd_nx = shreg[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          o_tx_done = 1'b1;
          state_nx  = IDLE;
          txd_nx    = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        txd_nx   = 1'b1;
      end
    endcase
  end

  // State, payload and registered serial line; reset aborts any frame and parks the line high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
      txd_q <= 1'b1;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      idx   <= idx_nx;
      txd_q <= txd_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine at 4 clocks per bit: frame-level model, per-cycle compare, serial decoder.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_engine;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       tx_ready, txd, tx_busy, tx_done;

  uart_tx_engine #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_tx_valid (valid),
    .i_tx_data  (data),
    .o_tx_ready (tx_ready),
    .o_txd      (txd),
    .o_tx_busy  (tx_busy),
    .o_tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame accepted at edge m_acc occupies the 40 cycles sampled after edges m_acc..m_acc+39
  int         ecnt = 0;
  bit         m_active = 1'b0;
  int         m_acc = 0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         done_cnt = 0;

  always @(posedge clk) begin
    ecnt = ecnt + 1;
    if (reset) begin
      if (m_active && (ecnt - 1 - m_acc) < FRAME) void'(exp_q.pop_back());
      m_active = 1'b0;
    end else if (valid && (!m_active || (ecnt - 1 - m_acc) >= FRAME)) begin
      m_active = 1'b1;
      m_acc    = ecnt;
      m_data   = data;
      exp_q.push_back(data);
    end
  end

  // Per-cycle compare against the model, plus an independent mid-bit serial decoder
  bit         dec_on = 1'b0;
  int         dec_t = 0;
  logic [7:0] dec_b = 8'h00;
  always @(negedge clk) begin
    logic e_txd, e_rdy, e_done;
    int   off, slot;
    e_txd  = 1'b1;
    e_rdy  = 1'b1;
    e_done = 1'b0;
    if (!reset && m_active && (ecnt - m_acc) < FRAME) begin
      off    = ecnt - m_acc;
      slot   = off / CPB;
      e_rdy  = 1'b0;
      e_done = (off == FRAME - 1);
      if (slot == 0)      e_txd = 1'b0;
      else if (slot <= 8) e_txd = m_data[slot-1];
      else                e_txd = 1'b1;
    end
    chk("cyc_txd", txd, e_txd);
    chk("cyc_ready", tx_ready, e_rdy);
    chk("cyc_busy", tx_busy, !e_rdy);
    chk("cyc_done", tx_done, e_done);
    if (tx_done === 1'b1) done_cnt++;

    if (reset) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (txd === 1'b0) begin
        dec_on = 1'b1;
        dec_t  = 0;
        dec_b  = 8'h00;
      end
    end else begin
      dec_t++;
      if (dec_t >= 6 && dec_t <= 34 && ((dec_t - 6) % 4) == 0) dec_b[(dec_t-6)/4] = txd;
      if (dec_t == 38) begin
        chk("rx_stop_bit", txd, 1'b1);
        rx_q.push_back(dec_b);
        dec_on = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    valid = 1'b1;
    data  = b;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (tx_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idle_in_time", (t < 200), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_rx(input logic [7:0] lit);
    chk("rx_avail", (rx_q.size() > 0), 1'b1);
    if (rx_q.size() > 0) chk("rx_byte", rx_q.pop_front(), lit);
    chk("model_avail", (exp_q.size() > 0), 1'b1);
    if (exp_q.size() > 0) chk("model_byte", exp_q.pop_front(), lit);
  endtask

  task automatic expect_empty();
    chk("rx_extra", rx_q.size(), 0);
    chk("model_extra", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a5_lit;
    int         first, rdy_cnt, fall_off, t, done_before;

    // Reset state
    @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5 against hand-written frame: start, 1,0,1,0,0,1,0,1, stop
    a5_lit = 10'b1_1010_0101_0;
    send_byte(8'hA5);
    for (int off = 0; off <= FRAME; off++) begin
      if (off % 4 == 2 && off < FRAME) chk("a5_bit", txd, a5_lit[off/4]);
      if (off == FRAME - 2) chk("a5_done_early", tx_done, 1'b0);
      if (off == FRAME - 1) chk("a5_done", tx_done, 1'b1);
      if (off == FRAME - 1) chk("a5_busy_last", tx_ready, 1'b0);
      if (off == FRAME)     chk("a5_ready_after", tx_ready, 1'b1);
      @(negedge clk);
    end
    wait_idle();
    expect_rx(8'hA5);
    expect_empty();

    // Back-to-back 0x00 then 0xFF with valid held: exactly one idle cycle between frames
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h00;
    @(negedge clk);
    first = m_acc;
    data  = 8'hFF;
    rdy_cnt  = 0;
    fall_off = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) rdy_cnt++;
      if (fall_off == 0 && i >= 36 && txd === 1'b0) fall_off = i;
    end
    valid = 1'b0;
    chk("b2b_idle_cycles", rdy_cnt, 1);
    chk("b2b_second_start", fall_off, 41);
    chk("b2b_model_gap", m_acc - first, 41);
    wait_idle();
    expect_rx(8'h00);
    expect_rx(8'hFF);
    expect_empty();

    // Valid pulsed with 0x3C during the data bits of 0x81 is ignored
    send_byte(8'h81);
    repeat (14) @(negedge clk);
    valid = 1'b1;
    data  = 8'h3C;
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    expect_rx(8'h81);
    expect_empty();

    // Reset mid-frame of 0x55: immediate abort, no done, then 0x0F goes out cleanly
    send_byte(8'h55);
    repeat (14) @(negedge clk);
    done_before = done_cnt;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1'b1);
    chk("async_rst_ready", tx_ready, 1'b1);
    chk("async_rst_busy", tx_busy, 1'b0);
    chk("async_rst_done", tx_done, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_byte(8'h0F);
    wait_idle();
    chk("abort_no_done", done_cnt - done_before, 1);
    expect_rx(8'h0F);
    expect_empty();

    // Data input toggling every cycle during frame 0xC3 has no effect
    send_byte(8'hC3);
    for (int i = 0; i < 45; i++) begin
      data = 8'($urandom);
      @(negedge clk);
    end
    wait_idle();
    expect_rx(8'hC3);
    expect_empty();

    // Valid held through reset: no acceptance until the first edge after release
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h5A;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_ready", tx_ready, 1'b1);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_accept_txd", txd, 1'b0);
    chk("post_rst_accept_busy", tx_busy, 1'b1);
    valid = 1'b0;
    wait_idle();
    expect_rx(8'h5A);
    expect_empty();

    // Random valid/data traffic, every frame checked by the model and the decoder
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 2) == 0);
      data  = 8'($urandom);
    end
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    chk("rand_frame_count", rx_q.size(), exp_q.size());
    t = 0;
    while (exp_q.size() > 0 && rx_q.size() > 0 && t < 200) begin
      chk("rand_byte", rx_q.pop_front(), exp_q.pop_front());
      t++;
    end
    expect_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; fixed 8N1 framing.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_tx_valid  input  1  byte offered for transmission.
REQ-006 SHALL have port i_tx_data  input  8  byte to send, sampled only on acceptance.
REQ-007 SHALL have port o_tx_ready  output  1  engine can accept a byte this cycle.
REQ-008 SHALL have port o_txd  output  1  serial line, idle high.
REQ-009 SHALL have port o_tx_busy  output  1  frame in progress.
REQ-010 SHALL have port o_tx_done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 Acceptance SHALL occur on a rising edge with i_tx_valid=1 and o_tx_ready=1; i_tx_data is latched into a shift register on that edge.
REQ-013 o_tx_ready SHALL be 1 only in IDLE; o_tx_busy SHALL equal NOT o_tx_ready.
REQ-014 On acceptance the FSM SHALL enter START; o_txd SHALL be 0 starting the cycle after acceptance (latency 1).
REQ-015 START, each DATA bit, and STOP SHALL each hold o_txd for exactly CLKS_PER_BIT cycles, timed by a bit counter cleared on every state/bit change.
REQ-016 DATA SHALL send bit 0 first (LSB first), 8 bits, via right-shift of the latched register; a 3-bit index counts 0..7, wrapping to STOP after index 7.
REQ-017 STOP SHALL drive o_txd=1; on its last cycle o_tx_done SHALL pulse 1 and the FSM SHALL return to IDLE next edge.
REQ-018 Total frame SHALL be 10*CLKS_PER_BIT cycles from first start-bit cycle to end of stop bit.
REQ-019 With i_tx_valid held high, the next frame SHALL be accepted in the first IDLE cycle, giving exactly one idle-high cycle between frames.
REQ-020 i_tx_valid while busy SHALL be ignored (no queueing, no error); i_tx_data changes mid-frame SHALL not affect the frame.
REQ-021 o_txd SHALL be registered (glitch-free); IDLE drives o_txd=1.
REQ-022 The bit counter SHALL be width $clog2(CLKS_PER_BIT) and never exceed CLKS_PER_BIT-1.

Reset
REQ-023 Reset assertion SHALL asynchronously force state=IDLE, o_txd=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0, counters and shift register=0.
REQ-024 Reset mid-frame SHALL abort the frame immediately; no o_tx_done pulse for it; first acceptance possible on the first edge after deassertion.

Structure
REQ-025 Shared package uart_pkg SHALL hold the state enum type, DATA_BITS, and default CLKS_PER_BIT constant, reused by the receiver side.
REQ-026 The bit-period counter SHALL be a sub-module uart_bit_timer (inputs clk, reset, clear; output tick on count CLKS_PER_BIT-1).

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte 0xA5 accepted at cycle 0 -> o_txd = 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles, from cycle 1; o_tx_done at cycle 40; ready at cycle 41.
REQ-028 Back-to-back 0x00 then 0xFF with valid held -> second start bit begins cycle 42; exactly one idle-high cycle between frames.
REQ-029 Valid pulsed with 0x3C during DATA of frame 0x81 -> only 0x81 appears on o_txd; 0x3C never sent.
REQ-030 Reset asserted at cycle 15 of frame 0x55 -> o_txd=1 and ready=1 asynchronously; no done pulse; new byte 0x0F sent correctly after release.
REQ-031 i_tx_data toggled every cycle during frame 0xC3 -> serial output still decodes 0xC3.
REQ-032 Reset with valid=1 held -> no acceptance while reset high; acceptance on first edge after release.
